exc_sweep_ctrl: RTL
===================

// Module: exc_sweep_ctrl
// PURPOSE
//  Sequencer for the sine-excitation / sigma-delta output path.
//  - Steps the phase-accumulator frequency tuning word (FTW) through an N-point linear sweep.
//  - At each point: settle window, then measurement window; o_trig marks the window start.
//  - Gates the excitation enable, so the sine LUT and modulator run only while a sweep is active.
// PARAMETERS
//  FTW_WIDTH   16  width of the tuning word fed to the phase accumulator
//  STEP_WIDTH   8  width of the step count / step index
//  CNT_WIDTH   16  width of the settle and measure dwell timers
// PORTS
//  i_clk         in   1           system clock
//  i_rst         in   1           synchronous, active-high reset
//  i_start       in   1           start request; sampled in IDLE only
//  i_abort       in   1           stop the sweep immediately
//  i_ftw_start   in   FTW_WIDTH   FTW of step 0
//  i_ftw_step    in   FTW_WIDTH   FTW increment per step
//  i_n_steps     in   STEP_WIDTH  number of sweep points
//  i_settle_cyc  in   CNT_WIDTH   settle dwell; window = value+1 cycles
//  i_meas_cyc    in   CNT_WIDTH   measure dwell; window = value+1 cycles
//  o_ftw         out  FTW_WIDTH   current tuning word, registered
//  o_en          out  1           excitation enable
//  o_phase_rst   out  1           1-cycle pulse on the first SETTLE cycle of every step
//  o_trig        out  1           1-cycle pulse on the first MEASURE cycle
//  o_meas        out  1           high for the whole MEASURE window
//  o_step_idx    out  STEP_WIDTH  index of the current step
//  o_busy        out  1           high in any state except IDLE
//  o_done        out  1           1-cycle pulse when the sweep completes normally
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; latched config 0. i_rst overrides all other inputs.
//  - States: IDLE, SETTLE, MEASURE, DONE. All outputs are registered.
//  - IDLE, i_start=1 and i_abort=0:
//      - latch i_ftw_step, i_n_steps, i_settle_cyc, i_meas_cyc, i_ftw_start;
//      - o_ftw<=i_ftw_start, step_idx<=0;
//      - if i_n_steps==0, go to DONE; otherwise go to SETTLE.
//  - Config inputs are ignored after start. i_start while busy is ignored.
//  - SETTLE: timer loads the latched settle value and counts down; at 0 go to MEASURE.
//    The window is settle+1 cycles.
//  - MEASURE: o_meas=1 and o_trig pulses on the first cycle. Window is meas+1 cycles. At its end:
//      - step_idx==n_steps-1: go to DONE;
//      - otherwise step_idx+=1, o_ftw+=ftw_step (modulo 2^FTW_WIDTH, wrap is silent), go to SETTLE.
//  - DONE: lasts 1 cycle with o_done=1, o_en=0, o_busy=1; then IDLE.
//  - o_en=1 in SETTLE and MEASURE only. o_ftw and o_step_idx hold their last values in IDLE.
//  - i_abort in SETTLE, MEASURE or DONE: IDLE on the next cycle.
//      - o_en, o_meas and o_busy drop; o_done does not pulse.
//  - i_abort and i_start together in IDLE: abort wins; stay IDLE.
//  - Back-to-back: i_start in the cycle after DONE (state now IDLE) is accepted normally.
// CONFIGURATION
//  - Macro SWEEP_AUTOREPEAT_EN.
//  - Defined: adds input port i_repeat (1 bit).
//      - At the end of the last MEASURE with i_repeat=1: o_ftw<=latched ftw_start, step_idx<=0,
//        go to SETTLE (o_phase_rst pulses), no DONE, no o_done.
//      - i_repeat=0 at that point: normal DONE.
//  - Undefined: no i_repeat port; the sweep always terminates in DONE.
// TESTING
//  1. Reset check: i_rst held 3 cycles mid-sweep -> every output 0 on the next cycle, state IDLE.
//  2. ftw_start=0x0100, ftw_step=0x0040, n=2, settle=2, meas=3, start at cycle 0:
//     - SETTLE cycles 1-3; MEASURE cycles 4-7 (o_trig at 4);
//     - SETTLE 8-10 with o_ftw=0x0140; MEASURE 11-14 (o_trig at 11);
//     - o_done at 15, o_busy=0 at 16.
//  3. n_steps=0 and start -> DONE next cycle, o_done pulse, o_en never 1, o_trig never 1.
//  4. ftw_start=0xFFF0, step=0x0020, n=2 -> second step o_ftw=0x0010 (wrap).
//  5. i_abort in the 2nd MEASURE cycle -> IDLE next cycle; o_meas=o_en=0; no o_done.
//     Also: i_start with i_abort in IDLE -> remains IDLE.
//  6. SWEEP_AUTOREPEAT_EN, i_repeat=1, n=2:
//     - after step 1, o_ftw returns to ftw_start and o_phase_rst pulses; no o_done;
//     - i_repeat=0 on the next pass -> o_done.

Source files
------------

// File: rtl/exc_sweep_ctrl.sv
// Linear FTW sweep sequencer for the sine-excitation / sigma-delta path: settle then measure per point.
// Optional macro SWEEP_AUTOREPEAT_EN adds i_repeat to restart the sweep instead of finishing.
module exc_sweep_ctrl #(
  parameter int unsigned FTW_WIDTH  = 16,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
`ifdef SWEEP_AUTOREPEAT_EN
  input  logic                  i_repeat,
`endif
  input  logic [FTW_WIDTH-1:0]  i_ftw_start,
  input  logic [FTW_WIDTH-1:0]  i_ftw_step,
  input  logic [STEP_WIDTH-1:0] i_n_steps,
  input  logic [CNT_WIDTH-1:0]  i_settle_cyc,
  input  logic [CNT_WIDTH-1:0]  i_meas_cyc,
  output logic [FTW_WIDTH-1:0]  o_ftw,
  output logic                  o_en,
  output logic                  o_phase_rst,
  output logic                  o_trig,
  output logic                  o_meas,
  output logic [STEP_WIDTH-1:0] o_step_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;
  logic [STEP_WIDTH-1:0] step_idx_q, step_idx_d;
  logic [FTW_WIDTH-1:0]  ftw_q, ftw_d;
  logic [FTW_WIDTH-1:0]  ftw_start_q, ftw_start_d;
  logic [FTW_WIDTH-1:0]  ftw_step_q, ftw_step_d;
  logic [STEP_WIDTH-1:0] n_steps_q, n_steps_d;
  logic [CNT_WIDTH-1:0]  settle_q, settle_d;
  logic [CNT_WIDTH-1:0]  meas_q, meas_d;
  logic                  en_q, en_d;
  logic                  phase_rst_q, phase_rst_d;
  logic                  trig_q, trig_d;
  logic                  meas_win_q, meas_win_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  repeat_c;
  logic                  last_step_c;

`ifdef SWEEP_AUTOREPEAT_EN
  assign repeat_c = i_repeat;
`else
  assign repeat_c = 1'b0;
`endif

  assign last_step_c = (step_idx_q == STEP_WIDTH'(n_steps_q - STEP_WIDTH'(1)));

  // State, datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      step_idx_q  <= '0;
      ftw_q       <= '0;
      ftw_start_q <= '0;
      ftw_step_q  <= '0;
      n_steps_q   <= '0;
      settle_q    <= '0;
      meas_q      <= '0;
      en_q        <= 1'b0;
      phase_rst_q <= 1'b0;
      trig_q      <= 1'b0;
      meas_win_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_idx_q  <= step_idx_d;
      ftw_q       <= ftw_d;
      ftw_start_q <= ftw_start_d;
      ftw_step_q  <= ftw_step_d;
      n_steps_q   <= n_steps_d;
      settle_q    <= settle_d;
      meas_q      <= meas_d;
      en_q        <= en_d;
      phase_rst_q <= phase_rst_d;
      trig_q      <= trig_d;
      meas_win_q  <= meas_win_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state; output flags describe the state being entered
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    step_idx_d  = step_idx_q;
    ftw_d       = ftw_q;
    ftw_start_d = ftw_start_q;
    ftw_step_d  = ftw_step_q;
    n_steps_d   = n_steps_q;
    settle_d    = settle_q;
    meas_d      = meas_q;
    en_d        = 1'b0;
    phase_rst_d = 1'b0;
    trig_d      = 1'b0;
    meas_win_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          ftw_start_d = i_ftw_start;
          ftw_step_d  = i_ftw_step;
          n_steps_d   = i_n_steps;
          settle_d    = i_settle_cyc;
          meas_d      = i_meas_cyc;
          ftw_d       = i_ftw_start;
          step_idx_d  = '0;
          busy_d      = 1'b1;
          if (i_n_steps == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_SETTLE;
            timer_d     = i_settle_cyc;
            en_d        = 1'b1;
            phase_rst_d = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          if (timer_q == '0) begin
            state_d    = ST_MEASURE;
            timer_d    = meas_q;
            meas_win_d = 1'b1;
            trig_d     = 1'b1;
          end else begin
            timer_d = timer_q - CNT_WIDTH'(1);
          end
        end
      end

      ST_MEASURE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (timer_q != '0) begin
          timer_d    = timer_q - CNT_WIDTH'(1);
          en_d       = 1'b1;
          meas_win_d = 1'b1;
          busy_d     = 1'b1;
        end else if (!last_step_c || repeat_c) begin
          // Next point, or wrap back to point 0 when auto-repeating
          state_d     = ST_SETTLE;
          timer_d     = settle_q;
          en_d        = 1'b1;
          phase_rst_d = 1'b1;
          busy_d      = 1'b1;
          if (last_step_c) begin
            step_idx_d = '0;
            ftw_d      = ftw_start_q;
          end else begin
            step_idx_d = step_idx_q + STEP_WIDTH'(1);
            ftw_d      = ftw_q + ftw_step_q;
          end
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_ftw       = ftw_q;
  assign o_en        = en_q;
  assign o_phase_rst = phase_rst_q;
  assign o_trig      = trig_q;
  assign o_meas      = meas_win_q;
  assign o_step_idx  = step_idx_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
